key_debounce_n: RTL and testbench
=================================

# key_debounce_n

Parametrised multi-key debouncer with edge and long-press event generation. It sits between raw mechanical push-button pins and the control logic, for example the PWM/dead-time setting logic. It synchronises each key and samples it on a shared prescaled tick. It publishes a debounced pressed level plus single-cycle press, release and long-press pulses per key.

## Interface
- `NUM_KEYS`, 4: number of independent key channels.
- `TICK_DIV`, 50000: clock cycles per sample tick (1 ms at 50 MHz); must be ≥ 2.
- `STABLE_TICKS`, 20: consecutive ticks a new level must persist before it is accepted; must be ≥ 1.
- `LONG_TICKS`, 1000: ticks in the debounced pressed state before `key_long` fires; must be ≥ 1.
- `ACTIVE_LOW`, 1: 1 means a raw key reads 0 when pressed; 0 means a raw key reads 1 when pressed.

Ports:
- `clock`, in, 1: single clock for the whole block.
- `reset`, in, 1: synchronous, active-high reset.
- `key`, in, NUM_KEYS: raw asynchronous key pins.
- `key_state`, out, NUM_KEYS: debounced level; 1 means pressed, regardless of `ACTIVE_LOW`.
- `key_press`, out, NUM_KEYS: one-cycle pulse on accepted press.
- `key_release`, out, NUM_KEYS: one-cycle pulse on accepted release.
- `key_long`, out, NUM_KEYS: one-cycle pulse once per press when the hold reaches `LONG_TICKS`.
- `tick`, out, 1: one-cycle sample strobe, exported for observability.

## Operation
- **Synchroniser:** a two-flop synchroniser per key. Reset value is the inactive level: all 1s if `ACTIVE_LOW`, otherwise all 0s. The normalised sample is `p = sync2 ^ ACTIVE_LOW`, where 1 means pressed.
- **Prescaler:**
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - `tick` is 1 exactly when the count equals TICK_DIV-1.
- **Per-key FSM:** states RELEASED, DEB_PRESS, PRESSED, DEB_RELEASE. All transitions are evaluated only on `tick`.
  - RELEASED: if p=1, set cnt=1. If STABLE_TICKS=1, accept immediately; otherwise go to DEB_PRESS.
  - DEB_PRESS:
    - If p=0, go to RELEASED with cnt=0.
    - Else, if cnt=STABLE_TICKS-1, go to PRESSED, pulse `key_press`, set cnt=0 and hold=0.
    - Else, cnt+1.
  - PRESSED:
    - If p=0, go to DEB_RELEASE with cnt=1, or accept the release immediately if STABLE_TICKS=1.
    - Otherwise, if hold<LONG_TICKS, hold+1. When hold reaches LONG_TICKS, pulse `key_long`.
  - DEB_RELEASE:
    - If p=1, go back to PRESSED with cnt=0; hold is frozen, neither cleared nor incremented.
    - Else, if cnt=STABLE_TICKS-1, go to RELEASED, pulse `key_release`, set cnt=0.
    - Else, cnt+1.
- **Output level:** `key_state` is 1 in PRESSED and DEB_RELEASE.
- **Counter widths and saturation:**
  - cnt is `$clog2(STABLE_TICKS+1)` bits.
  - hold is `$clog2(LONG_TICKS+1)` bits and saturates at LONG_TICKS, so `key_long` never repeats within one press.
- **Channel independence:** any combination of pulses may occur in the same cycle across keys.

## Timing
- Reset values: all outputs 0, prescaler 0, all FSMs in RELEASED, cnt and hold 0.
- Outputs are registered. `key_state` and its press/release pulse change on the same edge: the edge at which `tick` of the accepting sample is high.
- **Latency:** a clean edge on `key` reaches p after 2 clocks. Acceptance occurs on the STABLE_TICKS-th tick that samples the new level.
  - Total latency ≤ 2 + STABLE_TICKS·TICK_DIV clocks.
  - Total latency ≥ 2 + (STABLE_TICKS-1)·TICK_DIV + 1 clocks.
- **Long press:** `key_long` fires on the LONG_TICKS-th tick after the `key_press` edge, provided the key is held.
- **Pulse width:** each pulse is exactly 1 cycle wide. Pulses never coincide with a state where they are illogical; for example, `key_long` never fires when `key_state`=0.
- **Reset mid-operation:** the block returns to reset values on the next edge and emits no pulses. A key held through reset is re-debounced and yields `key_press` after STABLE_TICKS ticks.

## Structure
- Package `key_debounce_pkg` holds:
  - `typedef enum logic [1:0] key_st_t` {RELEASED, DEB_PRESS, PRESSED, DEB_RELEASE}.
  - Width helper constants/functions for the cnt and hold widths.
- Sub-module `key_debounce_chan` holds the synchroniser, FSM, cnt and hold for one key. The top level holds the prescaler and a generate loop of NUM_KEYS channels.

## Test plan
Common parameters: TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=5, NUM_KEYS=4, ACTIVE_LOW=1.
- **Clean press:** drive key=4'b1110 and hold it. Required: `key_state`=4'b0001 and `key_press`=4'b0001 for one cycle on the 3rd tick after sync. Other bits stay 0.
- **Bounce rejection:** toggle key[1] every 5 clocks for 60 clocks. Required: no pulses and `key_state[1]`=0. Then hold key[1] low; required: `key_press[1]` exactly 3 ticks later.
- **Long press:** hold key[0] for 30 ticks after press. Required: `key_long[0]` exactly once, on the 5th tick after `key_press`. On release, `key_release[0]` fires after 3 ticks and `key_long` does not repeat.
- **Simultaneous keys:** press key[2] and key[3] on the same cycle. Required: both `key_press` bits pulse on the same cycle; later simultaneous release gives both `key_release` bits on the same cycle.
- **Reset mid-operation:** assert `reset` for 1 cycle during DEB_PRESS, and again while PRESSED. Required: all outputs 0 on the next edge. A still-held key produces a fresh `key_press` 3 ticks after sync.
- **Active-high polarity:** instance with ACTIVE_LOW=0. Drive key[0]=1 and hold. Required: `key_press[0]` on the 3rd tick. A released line (0) gives no pulses out of reset.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and width helpers for the multi-key debouncer.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } key_st_t;

    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

    function automatic int hold_width(input int long_ticks);
        return $clog2(long_ticks + 1);
    endfunction

    function automatic int presc_width(input int tick_div);
        return $clog2(tick_div);
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: two-flop synchroniser, debounce FSM, stability and hold counters.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 20,
    parameter int LONG_TICKS   = 1000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic key_i,
    input  logic tick_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int CW = cnt_width(STABLE_TICKS);
    localparam int HW = hold_width(LONG_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

    logic          sync1_q;
    logic          sync2_q;
    key_st_t       state_q;
    logic [CW-1:0] cnt_q;
    logic [HW-1:0] hold_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          pressed;

    assign pressed = sync2_q ^ ACTIVE_LOW;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= ACTIVE_LOW;
            sync2_q   <= ACTIVE_LOW;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= key_i;
            sync2_q   <= sync1_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            if (tick_i) begin
                case (state_q)
                    RELEASED: begin
                        if (pressed) begin
                            if (STABLE_TICKS == 1) begin
                                state_q <= PRESSED;
                                press_q <= 1'b1;
                                cnt_q   <= '0;
                                hold_q  <= '0;
                            end else begin
                                state_q <= DEB_PRESS;
                                cnt_q   <= CW'(1);
                            end
                        end
                    end
                    DEB_PRESS: begin
                        if (!pressed) begin
                            state_q <= RELEASED;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= PRESSED;
                            press_q <= 1'b1;
                            cnt_q   <= '0;
                            hold_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!pressed) begin
                            if (STABLE_TICKS == 1) begin
                                state_q   <= RELEASED;
                                release_q <= 1'b1;
                                cnt_q     <= '0;
                            end else begin
                                state_q <= DEB_RELEASE;
                                cnt_q   <= CW'(1);
                            end
                        end else if (hold_q < HOLD_MAX) begin
                            // Saturating hold guarantees a single long pulse per press
                            hold_q <= hold_q + 1'b1;
                            if (hold_q == HOLD_MAX - 1'b1) long_q <= 1'b1;
                        end
                    end
                    DEB_RELEASE: begin
                        if (pressed) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q   <= RELEASED;
                            release_q <= 1'b1;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= RELEASED;
                endcase
            end
        end
    end

    assign state_o   = (state_q == PRESSED) || (state_q == DEB_RELEASE);
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_debounce_n.sv
// Multi-key debouncer top: shared sample prescaler feeding NUM_KEYS independent channels.
module key_debounce_n
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 20,
    parameter int LONG_TICKS   = 1000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic                tick
);

    localparam int PW = presc_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign tick = (presc_q == PRESC_LAST);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .STABLE_TICKS(STABLE_TICKS),
            .LONG_TICKS  (LONG_TICKS),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .key_i    (key[g]),
            .tick_i   (tick),
            .state_o  (key_state[g]),
            .press_o  (key_press[g]),
            .release_o(key_release[g]),
            .long_o   (key_long[g])
        );
    end

endmodule

// File: tb/tb_key_debounce_n.sv
// Bench for key_debounce_n: tick-level reference model feeding a per-cycle scoreboard plus directed latency checks.
module tb_key_debounce_n;

    localparam int NK     = 4;
    localparam int DIV    = 4;
    localparam int STABLE = 3;
    localparam int LONG   = 5;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lg;
        logic       tk;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] keyA  = 4'hF;
    logic [3:0] keyB  = 4'h0;
    logic [3:0] stateA, pressA, releaseA, longA;
    logic [3:0] stateB, pressB, releaseB, longB;
    logic       tickA, tickB;

    int checkCount = 0;
    int failCount  = 0;

    exp_t qA[$];
    exp_t qB[$];

    int pressCnt[2][NK];
    int releaseCnt[2][NK];
    int longCnt[2][NK];

    int mPresc = 0;
    bit mS1[2][NK];
    bit mS2[2][NK];
    bit mLevel[2][NK];
    int mAgree[2][NK];
    int mHold[2][NK];
    exp_t eNext[2];

    key_debounce_n #(.NUM_KEYS(NK), .TICK_DIV(DIV), .STABLE_TICKS(STABLE),
                     .LONG_TICKS(LONG), .ACTIVE_LOW(1'b1)) dutA (
        .clock(clock), .reset(reset), .key(keyA), .key_state(stateA),
        .key_press(pressA), .key_release(releaseA), .key_long(longA), .tick(tickA));

    key_debounce_n #(.NUM_KEYS(NK), .TICK_DIV(DIV), .STABLE_TICKS(STABLE),
                     .LONG_TICKS(LONG), .ACTIVE_LOW(1'b0)) dutB (
        .clock(clock), .reset(reset), .key(keyB), .key_state(stateB),
        .key_press(pressB), .key_release(releaseB), .key_long(longB), .tick(tickB));

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: debounced level flips after STABLE consecutive disagreeing ticks
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) eNext[i] = '0;
        if (reset) begin
            mPresc = 0;
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < NK; k++) begin
                    mS1[i][k] = (i == 0); mS2[i][k] = (i == 0);
                    mLevel[i][k] = 1'b0; mAgree[i][k] = 0; mHold[i][k] = 0;
                end
        end else begin
            bit tk;
            tk = (mPresc == DIV - 1);
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < NK; k++) begin
                    bit p;
                    p = mS2[i][k] ^ (i == 0);
                    if (tk) begin
                        if (p != mLevel[i][k]) begin
                            mAgree[i][k]++;
                            if (mAgree[i][k] == STABLE) begin
                                mLevel[i][k] = p;
                                mAgree[i][k] = 0;
                                if (p) begin eNext[i].pr[k] = 1'b1; mHold[i][k] = 0; end
                                else   eNext[i].rl[k] = 1'b1;
                            end
                        end else begin
                            if (mLevel[i][k] && mAgree[i][k] == 0 && mHold[i][k] < LONG) begin
                                mHold[i][k]++;
                                if (mHold[i][k] == LONG) eNext[i].lg[k] = 1'b1;
                            end
                            mAgree[i][k] = 0;
                        end
                    end
                    mS2[i][k] = mS1[i][k];
                    mS1[i][k] = (i == 0) ? keyA[k] : keyB[k];
                    eNext[i].st[k] = mLevel[i][k];
                end
            mPresc = tk ? 0 : mPresc + 1;
            for (int i = 0; i < 2; i++) eNext[i].tk = (mPresc == DIV - 1);
        end
        qA.push_back(eNext[0]);
        qB.push_back(eNext[1]);
    end

    // Scoreboard compare and pulse bookkeeping, away from the active edge
    always @(negedge clock) begin
        exp_t e;
        if (qA.size() > 0) begin
            e = qA.pop_front();
            checkOutput("stateA", stateA, e.st);
            checkOutput("pressA", pressA, e.pr);
            checkOutput("releaseA", releaseA, e.rl);
            checkOutput("longA", longA, e.lg);
            checkOutput("tickA", tickA, e.tk);
        end
        if (qB.size() > 0) begin
            e = qB.pop_front();
            checkOutput("stateB", stateB, e.st);
            checkOutput("pressB", pressB, e.pr);
            checkOutput("releaseB", releaseB, e.rl);
            checkOutput("longB", longB, e.lg);
            checkOutput("tickB", tickB, e.tk);
        end
        for (int k = 0; k < NK; k++) begin
            pressCnt[0][k]   += int'(pressA[k]);
            releaseCnt[0][k] += int'(releaseA[k]);
            longCnt[0][k]    += int'(longA[k]);
            pressCnt[1][k]   += int'(pressB[k]);
            releaseCnt[1][k] += int'(releaseB[k]);
            longCnt[1][k]    += int'(longB[k]);
        end
    end

    task automatic applyStimulus(input int inst, input logic [3:0] v);
        @(negedge clock);
        if (inst == 0) keyA = v;
        else keyB = v;
    endtask

    function automatic logic [3:0] pulseOf(input int inst, input int sel);
        case (sel)
            0: return (inst == 0) ? pressA : pressB;
            1: return (inst == 0) ? releaseA : releaseB;
            default: return (inst == 0) ? longA : longB;
        endcase
    endfunction

    task automatic waitEvent(input string tag, input int inst, input int sel,
                             input logic [3:0] mask, input int expTicks, input bit skipSync);
        int  ticks;
        bit  found;
        ticks = 0;
        found = 1'b0;
        if (skipSync) repeat (2) @(negedge clock);
        for (int c = 0; c < 200 && !found; c++) begin
            if (tickA) ticks++;
            @(negedge clock);
            if ((pulseOf(inst, sel) & mask) == mask) found = 1'b1;
        end
        if (found) checkOutput(tag, ticks, expTicks);
        else checkOutput({tag, "_timeout"}, 0, 1);
    endtask

    task automatic pulseReset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rstState", stateA, 4'h0);
        checkOutput("rstPulses", {pressA, releaseA, longA}, 12'h0);
        checkOutput("rstTick", tickA, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int snapLong, snapPress, snapRel;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkOutput("initState", {stateA, stateB}, 8'h0);
        repeat (10) @(negedge clock);

        applyStimulus(0, 4'b1110);
        waitEvent("cleanPress", 0, 0, 4'b0001, STABLE, 1'b1);
        checkOutput("cleanStateVal", stateA, 4'b0001);
        checkOutput("cleanPressVal", pressA, 4'b0001);
        applyStimulus(0, 4'b1111);
        waitEvent("cleanRelease", 0, 1, 4'b0001, STABLE, 1'b1);

        snapPress = pressCnt[0][1];
        snapRel   = releaseCnt[0][1];
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, (i % 2 == 0) ? 4'b1101 : 4'b1111);
            repeat (4) @(negedge clock);
        end
        checkOutput("bouncePress", pressCnt[0][1] - snapPress, 0);
        checkOutput("bounceRelease", releaseCnt[0][1] - snapRel, 0);
        checkOutput("bounceState", stateA[1], 1'b0);
        applyStimulus(0, 4'b1101);
        waitEvent("bounceHoldPress", 0, 0, 4'b0010, STABLE, 1'b1);
        applyStimulus(0, 4'b1111);
        waitEvent("bounceHoldRelease", 0, 1, 4'b0010, STABLE, 1'b1);

        snapLong = longCnt[0][0];
        applyStimulus(0, 4'b1110);
        waitEvent("longPress", 0, 0, 4'b0001, STABLE, 1'b1);
        waitEvent("longFire", 0, 2, 4'b0001, LONG, 1'b0);
        checkOutput("longState", stateA[0], 1'b1);
        for (int t = 0; t < 25; ) begin
            if (tickA) t++;
            @(negedge clock);
        end
        applyStimulus(0, 4'b1111);
        waitEvent("longRelease", 0, 1, 4'b0001, STABLE, 1'b1);
        checkOutput("longOnce", longCnt[0][0] - snapLong, 1);

        applyStimulus(0, 4'b0011);
        waitEvent("simulPress", 0, 0, 4'b0100, STABLE, 1'b1);
        checkOutput("simulPressPair", pressA[3:2], 2'b11);
        repeat (6) @(negedge clock);
        applyStimulus(0, 4'b1111);
        waitEvent("simulRelease", 0, 1, 4'b0100, STABLE, 1'b1);
        checkOutput("simulReleasePair", releaseA[3:2], 2'b11);

        applyStimulus(0, 4'b1110);
        repeat (7) @(negedge clock);
        pulseReset();
        waitEvent("rstDebPress", 0, 0, 4'b0001, STABLE, 1'b1);
        repeat (6) @(negedge clock);
        pulseReset();
        waitEvent("rstHeldPress", 0, 0, 4'b0001, STABLE, 1'b1);
        applyStimulus(0, 4'b1111);
        waitEvent("rstRelease", 0, 1, 4'b0001, STABLE, 1'b1);

        checkOutput("polIdlePulses",
                    pressCnt[1][0] + releaseCnt[1][0] + longCnt[1][0] + pressCnt[1][3], 0);
        checkOutput("polIdleState", stateB, 4'h0);
        applyStimulus(1, 4'b0001);
        waitEvent("polPress", 1, 0, 4'b0001, STABLE, 1'b1);
        checkOutput("polState", stateB, 4'b0001);
        applyStimulus(1, 4'b0000);
        waitEvent("polRelease", 1, 1, 4'b0001, STABLE, 1'b1);

        repeat (8) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
